// File: rtl/csat_enum_pkg.sv
// Shared types and defaults for the SAT candidate enumerator.
// The enumerator steps through every assignment of a SAT circuit under test.
package csat_enum_pkg;

  localparam int unsigned DEF_NUM_VARS     = 11;
  localparam int unsigned DEF_EVAL_LATENCY = 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EVAL,
    S_CHECK,
    S_REPORT
  } state_t;

  // A latency of zero still needs a one-bit counter.
  function automatic int unsigned lat_width(input int unsigned lat);
    return (lat == 0) ? 1 : $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/sat_enumerator_if.sv
// Result handshake bundle of the SAT enumerator.
// The enumerator is the master and drives everything except res_ready.
interface sat_enumerator_if
  import csat_enum_pkg::*;
#(
  parameter int unsigned NUM_VARS = DEF_NUM_VARS
);

  logic                res_valid;
  logic                res_ready;
  logic                res_found;
  logic                res_aborted;
  logic [NUM_VARS-1:0] res_solution;
  logic [NUM_VARS:0]   res_count;

  modport master (
    output res_valid, res_found, res_aborted, res_solution, res_count,
    input  res_ready
  );

  modport slave (
    input  res_valid, res_found, res_aborted, res_solution, res_count,
    output res_ready
  );

endinterface

// File: rtl/csat_lat_counter.sv
// Loadable down-counter that times how long a candidate is held
// before the SAT circuit output is trusted.
module csat_lat_counter #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - WIDTH'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/sat_enumerator.sv
// Brute-force SAT search: drives ascending candidates into an external circuit,
// waits out its latency, samples sat_i and reports the first hit or exhaustion.
module sat_enumerator
  import csat_enum_pkg::*;
#(
  parameter int unsigned NUM_VARS     = DEF_NUM_VARS,
  parameter int unsigned EVAL_LATENCY = DEF_EVAL_LATENCY
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  output logic [NUM_VARS-1:0] cand_o,
  input  logic                sat_i,
  output logic                busy,
  sat_enumerator_if.master    res
);

  localparam int unsigned LAT_W = lat_width(EVAL_LATENCY);

  state_t              r_state;
  logic [NUM_VARS-1:0] r_cand;
  logic [NUM_VARS:0]   r_count;
  logic                r_busy;
  logic                r_res_valid;
  logic                r_res_found;
  logic                r_res_aborted;
  logic [NUM_VARS-1:0] r_res_solution;
  logic [NUM_VARS:0]   r_res_count;

  logic                w_lat_load;
  logic                w_lat_dec;
  logic                w_lat_zero;
  logic [NUM_VARS:0]   w_count_inc;
  logic                w_done;

  // Every entry into EVAL comes from IDLE or CHECK, so reloading outside EVAL suffices.
  assign w_lat_load  = (r_state != S_EVAL);
  assign w_lat_dec   = (r_state == S_EVAL);
  assign w_count_inc = r_count + (NUM_VARS + 1)'(1);
  assign w_done      = sat_i || abort || (&r_cand);

  csat_lat_counter #(
    .WIDTH (LAT_W)
  ) u_lat (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_lat_load),
    .i_load_val (LAT_W'(EVAL_LATENCY)),
    .i_dec      (w_lat_dec),
    .o_zero     (w_lat_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_cand         <= '0;
      r_count        <= '0;
      r_busy         <= 1'b0;
      r_res_valid    <= 1'b0;
      r_res_found    <= 1'b0;
      r_res_aborted  <= 1'b0;
      r_res_solution <= '0;
      r_res_count    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state        <= S_EVAL;
            r_busy         <= 1'b1;
            r_cand         <= '0;
            r_count        <= '0;
            r_res_found    <= 1'b0;
            r_res_aborted  <= 1'b0;
            r_res_solution <= '0;
            r_res_count    <= '0;
          end
        end
        S_EVAL: begin
          if (abort) begin
            r_state        <= S_REPORT;
            r_res_valid    <= 1'b1;
            r_res_found    <= 1'b0;
            r_res_aborted  <= 1'b1;
            r_res_solution <= '0;
            r_res_count    <= r_count;
          end else if (w_lat_zero) begin
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          r_count <= w_count_inc;
          // A hit in the same cycle as abort is still reported as found.
          if (w_done) begin
            r_state        <= S_REPORT;
            r_res_valid    <= 1'b1;
            r_res_found    <= sat_i;
            r_res_aborted  <= !sat_i && abort;
            r_res_solution <= sat_i ? r_cand : '0;
            r_res_count    <= w_count_inc;
          end else begin
            r_cand  <= r_cand + NUM_VARS'(1);
            r_state <= S_EVAL;
          end
        end
        S_REPORT: begin
          if (res.res_ready) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_res_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign cand_o           = r_cand;
  assign busy             = r_busy;
  assign res.res_valid    = r_res_valid;
  assign res.res_found    = r_res_found;
  assign res.res_aborted  = r_res_aborted;
  assign res.res_solution = r_res_solution;
  assign res.res_count    = r_res_count;

endmodule

// File: tb/tb_sat_enumerator.sv
// Self-checking bench for sat_enumerator: three configurations, a vector table
// for the 11-variable search and hand-written sequences for timing and reset.
module tb_sat_enumerator;

  typedef struct {
    int unsigned target;
    bit          en;
    int          abort_cand;
    bit          abort_check;
    bit          found;
    bit          aborted;
    int unsigned sol;
    int unsigned count;
  } vec_t;

  typedef struct {
    logic        found;
    logic        aborted;
    logic [31:0] sol;
    logic [31:0] count;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start0, start1, start2;
  logic        abort0, abort_off;
  logic [10:0] cand0;
  logic [3:0]  cand1;
  logic [5:0]  cand2;
  logic        busy0, busy1, busy2;
  logic        sat0, sat1, sat2;
  logic        sat_en0;
  logic [10:0] target0;
  logic [2:0]  pipe2 = '0;

  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t sb[$];
  vec_t vecs[9];

  sat_enumerator_if #(.NUM_VARS(11)) if0 ();
  sat_enumerator_if #(.NUM_VARS(4))  if1 ();
  sat_enumerator_if #(.NUM_VARS(6))  if2 ();

  assign sat0 = sat_en0 && (cand0 == target0);
  assign sat1 = 1'b0;
  always @(posedge clk) pipe2 <= {pipe2[1:0], (cand2 == 6'd5)};
  assign sat2 = pipe2[2];

  sat_enumerator #(.NUM_VARS(11), .EVAL_LATENCY(0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .cand_o(cand0),
    .sat_i(sat0), .busy(busy0), .res(if0));

  sat_enumerator #(.NUM_VARS(4), .EVAL_LATENCY(0)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort_off), .cand_o(cand1),
    .sat_i(sat1), .busy(busy1), .res(if1));

  sat_enumerator #(.NUM_VARS(6), .EVAL_LATENCY(3)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort_off), .cand_o(cand2),
    .sat_i(sat2), .busy(busy2), .res(if2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sb_check(input string tag, input logic found, input logic aborted,
                          input logic [31:0] sol, input logic [31:0] count);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s_sb: got a result, expected none pending", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_found"},   {31'd0, found},   {31'd0, e.found});
    chk({tag, "_aborted"}, {31'd0, aborted}, {31'd0, e.aborted});
    chk({tag, "_sol"},     sol,   e.sol);
    chk({tag, "_count"},   count, e.count);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    exp_t        e;
    int          cyc;
    logic [10:0] prev;
    bit          first;
    bit          eval_ph;
    target0   = 11'(v.target);
    sat_en0   = v.en;
    e.found   = v.found;
    e.aborted = v.aborted;
    e.sol     = v.sol;
    e.count   = v.count;
    sb.push_back(e);
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    chk({tag, "_cand_start"}, {21'd0, cand0}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy0}, 32'd1);
    first = 1'b1;
    prev  = '0;
    cyc   = 0;
    while (!if0.res_valid && cyc < 5000) begin
      eval_ph = first || (cand0 != prev);
      abort0  = 1'b0;
      start0  = 1'b0;
      if (v.abort_cand >= 0 && cand0 == 11'(v.abort_cand) && (eval_ph != v.abort_check))
        abort0 = 1'b1;
      // Start while busy must be ignored.
      if (cand0 == 11'd10 && eval_ph) start0 = 1'b1;
      prev  = cand0;
      first = 1'b0;
      @(negedge clk);
      cyc++;
    end
    abort0 = 1'b0;
    start0 = 1'b0;
    chk({tag, "_done"}, {31'd0, if0.res_valid}, 32'd1);
    if (!if0.res_valid) begin
      void'(sb.pop_front());
      return;
    end
    for (int h = 0; h < 3; h++) begin
      chk({tag, "_hold_valid"}, {31'd0, if0.res_valid}, 32'd1);
      chk({tag, "_hold_count"}, {20'd0, if0.res_count}, e.count);
      chk({tag, "_hold_sol"},   {21'd0, if0.res_solution}, e.sol);
      start0 = (h == 0);
      abort0 = (h == 0);
      @(negedge clk);
    end
    start0        = 1'b0;
    abort0        = 1'b0;
    if0.res_ready = 1'b1;
    sb_check(tag, if0.res_found, if0.res_aborted, {21'd0, if0.res_solution}, {20'd0, if0.res_count});
    @(negedge clk) if0.res_ready = 1'b0;
    chk({tag, "_valid_drop"}, {31'd0, if0.res_valid}, 32'd0);
    chk({tag, "_idle"}, {31'd0, busy0}, 32'd0);
    chk({tag, "_keep_count"}, {20'd0, if0.res_count}, e.count);
    chk({tag, "_keep_found"}, {31'd0, if0.res_found}, {31'd0, e.found});
    @(negedge clk);
    chk({tag, "_still_idle"}, {31'd0, busy0}, 32'd0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int k;
    int errs;

    vecs[0] = '{'h2A5, 1'b1, -1, 1'b0, 1'b1, 1'b0, 'h2A5, 678};
    vecs[1] = '{'h000, 1'b1, -1, 1'b0, 1'b1, 1'b0, 'h000, 1};
    vecs[2] = '{'h7FF, 1'b1, -1, 1'b0, 1'b1, 1'b0, 'h7FF, 2048};
    vecs[3] = '{'h000, 1'b0, -1, 1'b0, 1'b0, 1'b0, 'h000, 2048};
    vecs[4] = '{'h000, 1'b0, 20, 1'b0, 1'b0, 1'b1, 'h000, 20};
    vecs[5] = '{'h014, 1'b1, 20, 1'b1, 1'b1, 1'b0, 'h014, 21};
    vecs[6] = '{'h000, 1'b0, 20, 1'b1, 1'b0, 1'b1, 'h000, 21};
    vecs[7] = '{'h000, 1'b0,  0, 1'b0, 1'b0, 1'b1, 'h000, 0};
    vecs[8] = '{'h003, 1'b1,  3, 1'b0, 1'b0, 1'b1, 'h000, 3};

    rst_n = 1'b0;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    abort0 = 1'b0; abort_off = 1'b0;
    sat_en0 = 1'b0; target0 = '0;
    if0.res_ready = 1'b0; if1.res_ready = 1'b0; if2.res_ready = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_cand0",  {21'd0, cand0}, 32'd0);
    chk("rst_busy0",  {31'd0, busy0}, 32'd0);
    chk("rst_valid0", {31'd0, if0.res_valid}, 32'd0);
    chk("rst_found0", {31'd0, if0.res_found}, 32'd0);
    chk("rst_abrt0",  {31'd0, if0.res_aborted}, 32'd0);
    chk("rst_sol0",   {21'd0, if0.res_solution}, 32'd0);
    chk("rst_count0", {20'd0, if0.res_count}, 32'd0);
    chk("rst_busy1",  {31'd0, busy1}, 32'd0);
    chk("rst_busy2",  {31'd0, busy2}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Four variables, never satisfiable: 16 candidates, two cycles each.
    sb.push_back('{1'b0, 1'b0, 32'd0, 32'd16});
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    k = 0; errs = 0;
    while (!if1.res_valid && k < 200) begin
      if (cand1 != 4'(k / 2)) errs++;
      k++;
      @(negedge clk);
    end
    chk("u1_cycles", k, 32'd32);
    chk("u1_seq_err", errs, 32'd0);
    if1.res_ready = 1'b1;
    sb_check("u1", if1.res_found, if1.res_aborted, {28'd0, if1.res_solution}, {27'd0, if1.res_count});
    @(negedge clk) if1.res_ready = 1'b0;
    chk("u1_idle", {31'd0, busy1}, 32'd0);

    // Latency 3 with a three-stage registered circuit: hit at 5, five cycles per candidate.
    sb.push_back('{1'b1, 1'b0, 32'd5, 32'd6});
    @(negedge clk) start2 = 1'b1;
    @(negedge clk) start2 = 1'b0;
    k = 0; errs = 0;
    while (!if2.res_valid && k < 200) begin
      if (cand2 != 6'(k / 5)) errs++;
      k++;
      @(negedge clk);
    end
    chk("u2_cycles", k, 32'd30);
    chk("u2_seq_err", errs, 32'd0);
    if2.res_ready = 1'b1;
    sb_check("u2", if2.res_found, if2.res_aborted, {26'd0, if2.res_solution}, {25'd0, if2.res_count});
    @(negedge clk) if2.res_ready = 1'b0;
    chk("u2_idle", {31'd0, busy2}, 32'd0);

    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Asynchronous reset in the middle of a search.
    target0 = '0; sat_en0 = 1'b0;
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    cyc = 0;
    while (cand0 != 11'd100 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    chk("rst_reach100", {21'd0, cand0}, 32'd100);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cand",  {21'd0, cand0}, 32'd0);
    chk("arst_busy",  {31'd0, busy0}, 32'd0);
    chk("arst_valid", {31'd0, if0.res_valid}, 32'd0);
    chk("arst_sol",   {21'd0, if0.res_solution}, 32'd0);
    chk("arst_count", {20'd0, if0.res_count}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("arst_no_resume", {20'd0, busy0, cand0}, 32'd0);
    end
    run_vec(vecs[0], "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
